tone_scheduler: RTL and testbench



---
 rtl/tone_scheduler_pkg.sv | 37 +++
 rtl/tone_scheduler_if.sv | 11 +
 rtl/tone_scheduler_prio_enc.sv | 30 +++
 rtl/tone_scheduler.sv | 139 +++++++++++++
 tb/tb_tone_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_scheduler_pkg.sv
// Shared constants, state encoding and note-word layout for the tone scheduler slice.
package tone_scheduler_pkg;

    localparam int CLK_FRE          = 50_000_000;
    localparam int DEFAULT_TICK_DIV = CLK_FRE / 1000;

    localparam int NOTE_HI = 31;
    localparam int NOTE_LO = 24;
    localparam int VELO_HI = 23;
    localparam int VELO_LO = 16;
    localparam int TIME_HI = 15;
    localparam int TIME_LO = 0;

    localparam int PRESC_W  = 20;
    localparam int REMAIN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } schedState_t;

    typedef struct packed {
        logic [7:0]  note;
        logic [7:0]  velo;
        logic [15:0] timeMs;
    } noteWord_t;

    function automatic noteWord_t unpackWord(input logic [31:0] raw);
        noteWord_t w;
        w.note   = raw[NOTE_HI:NOTE_LO];
        w.velo   = raw[VELO_HI:VELO_LO];
        w.timeMs = raw[TIME_HI:TIME_LO];
        return w;
    endfunction

endpackage

// File: rtl/tone_scheduler_if.sv
// Requester-side valid/ready bus carrying one 32-bit note word per requester.
interface tone_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/tone_scheduler_prio_enc.sv
// Lowest-index-wins one-hot grant and binary index over a masked request vector.
module tone_prio_enc #(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grantOh,
    output logic [OWN_W-1:0]   grantIdx,
    output logic               grantAny
);
    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & mask;
    assign grantAny = |eligible;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        grantOh  = '0;
        grantIdx = '0;
        // Scan from the top down so the lowest eligible index is the last writer.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grantOh    = '0;
                grantOh[i] = 1'b1;
                grantIdx   = OWN_W'(i);
            end
        end
    end
endmodule

// File: rtl/tone_scheduler.sv
// Fixed-priority buzzer scheduler: grants note words, times them in ms ticks, optional gap.
// Build option: define TONE_SCHED_PREEMPT_EN to let a lower-index requester preempt a note or gap.
module tone_scheduler
    import tone_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int GAP_MS   = 0,
    parameter int OWN_W    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    tone_scheduler_if.slave      reqBus,
    input  logic                 abort,
    output logic [7:0]           tone_note,
    output logic [7:0]           tone_velo,
    output logic                 tone_en,
    output logic                 busy,
    output logic [OWN_W-1:0]     owner,
    output logic [NUM_REQ-1:0]   done
);
    localparam logic [PRESC_W-1:0]  TICK_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [REMAIN_W-1:0] GAP_LOAD  = REMAIN_W'(GAP_MS);

    schedState_t          state;
    logic [PRESC_W-1:0]   prescaler;
    logic [REMAIN_W-1:0]  remain;
    logic [NUM_REQ-1:0]   prioMask;
    logic [NUM_REQ-1:0]   grantOh;
    logic [NUM_REQ-1:0]   ownerOh;
    logic [OWN_W-1:0]     grantIdx;
    logic                 grantAny;
    logic                 xfer;
    logic                 tick;
    noteWord_t            word;

`ifdef TONE_SCHED_PREEMPT_EN
    // Outside IDLE only indices strictly below the current owner may win.
    always_comb begin
        prioMask = '1;
        if (state != IDLE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                prioMask[i] = (i < int'(owner));
            end
        end
    end
`else
    assign prioMask = (state == IDLE) ? '1 : '0;
`endif

    tone_prio_enc #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) uPrioEnc (
        .req      (reqBus.req_valid),
        .mask     (prioMask),
        .grantOh  (grantOh),
        .grantIdx (grantIdx),
        .grantAny (grantAny)
    );

    assign xfer             = grantAny & ~abort;
    assign reqBus.req_ready = xfer ? grantOh : '0;
    assign tick             = (prescaler == TICK_LAST);
    assign ownerOh          = NUM_REQ'(1) << owner;

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantOh[i]) word = unpackWord(reqBus.req_data[32*i +: 32]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            prescaler <= '0;
            remain    <= '0;
            tone_note <= '0;
            tone_velo <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            owner     <= '0;
            done      <= '0;
        end else begin
            // NOTE: non-blocking throughout so every decision uses pre-edge register values.
            done <= '0;
            if (xfer) begin
                owner     <= grantIdx;
                tone_velo <= word.velo;
                prescaler <= '0;
                if (word.timeMs == '0) begin
                    // Zero-length word is consumed without ever entering PLAY.
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remain    <= '0;
                    tone_note <= '0;
                    tone_en   <= 1'b0;
                    done      <= grantOh;
                end else begin
                    state     <= PLAY;
                    busy      <= 1'b1;
                    remain    <= word.timeMs;
                    tone_note <= word.note;
                    tone_en   <= (word.note != '0);
                end
            end else if (state != IDLE) begin
                if (abort) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remain    <= '0;
                    prescaler <= '0;
                    tone_note <= '0;
                    tone_en   <= 1'b0;
                end else if (tick) begin
                    prescaler <= '0;
                    if (remain == REMAIN_W'(1)) begin
                        tone_note <= '0;
                        tone_en   <= 1'b0;
                        if (state == PLAY) done <= ownerOh;
                        if (state == PLAY && GAP_MS != 0) begin
                            state  <= GAP;
                            busy   <= 1'b1;
                            remain <= GAP_LOAD;
                        end else begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            remain <= '0;
                        end
                    end else begin
                        remain <= remain - 1'b1;
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed and random note traffic checked against an arithmetic timing model.
module tb_tone_scheduler;
    import tone_scheduler_pkg::*;

    localparam int NREQ  = 4;
    localparam int TDIV  = 4;
    localparam int GAPMS = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       abort0, abortG;
    logic [7:0] note0, velo0, noteG, veloG;
    logic       en0, enG, busy0, busyG;
    logic [1:0] owner0, ownerG;
    logic [3:0] done0, doneG;

    int checks = 0;
    int errors = 0;

    tone_scheduler_if #(.NUM_REQ(NREQ)) bus0 ();
    tone_scheduler_if #(.NUM_REQ(NREQ)) busG ();

    tone_scheduler #(.NUM_REQ(NREQ), .TICK_DIV(TDIV), .GAP_MS(0), .OWN_W(2)) dut0 (
        .clk(clk), .rstn(rstn), .reqBus(bus0), .abort(abort0),
        .tone_note(note0), .tone_velo(velo0), .tone_en(en0), .busy(busy0),
        .owner(owner0), .done(done0)
    );

    tone_scheduler #(.NUM_REQ(NREQ), .TICK_DIV(TDIV), .GAP_MS(GAPMS), .OWN_W(2)) dutG (
        .clk(clk), .rstn(rstn), .reqBus(busG), .abort(abortG),
        .tone_note(noteG), .tone_velo(veloG), .tone_en(enG), .busy(busyG),
        .owner(ownerG), .done(doneG)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] randWord(input int maxMs);
        logic [7:0]  n;
        logic [7:0]  v;
        logic [15:0] t;
        n = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        v = 8'($urandom);
        t = 16'($urandom_range(0, maxMs));
        return {n, v, t};
    endfunction

    // Model: lowest set valid wins; a word of t ms plays t*TDIV cycles, then done pulses once.
    task automatic serveAll(input logic [3:0] mask, input logic [127:0] words);
        logic [3:0]  m;
        logic [3:0]  expGrant;
        logic [7:0]  nt;
        logic [7:0]  vl;
        logic [15:0] t;
        int          idx;
        m = mask;
        bus0.req_data  = words;
        bus0.req_valid = m;
        #1;
        while (m != 4'd0) begin
            expGrant = m & (~m + 4'd1);
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (expGrant[i]) idx = i;
            nt = words[idx*32+24 +: 8];
            vl = words[idx*32+16 +: 8];
            t  = words[idx*32 +: 16];
            check("grant", 32'(bus0.req_ready), 32'(expGrant));
            nextCycle();
            m = m & ~expGrant;
            bus0.req_valid = m;
            #1;
            if (t == 16'd0) begin
                check("zero_done", 32'(done0), 32'(expGrant));
                check("zero_en", 32'(en0), 0);
                check("zero_busy", 32'(busy0), 0);
            end else begin
                for (int c = 0; c < int'(t) * TDIV; c++) begin
                    check("play_en", 32'(en0), 32'(nt != 8'd0));
                    check("play_note", 32'(note0), 32'(nt));
                    check("play_velo", 32'(velo0), 32'(vl));
                    check("play_busy", 32'(busy0), 1);
                    check("play_done", 32'(done0), 0);
                    check("play_ready", 32'(bus0.req_ready), 0);
                    nextCycle();
                    #1;
                end
                check("end_done", 32'(done0), 32'(expGrant));
                check("end_en", 32'(en0), 0);
                check("end_note", 32'(note0), 0);
                check("end_busy", 32'(busy0), 0);
            end
            check("owner", 32'(owner0), 32'(idx));
        end
        nextCycle();
        #1;
        check("done_clear", 32'(done0), 0);
    endtask

    initial begin
        logic [127:0] words;
        logic [3:0]   mask;
        int           abortAt;

        rstn = 1'b0;
        abort0 = 1'b0;
        abortG = 1'b0;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        busG.req_valid = '0;
        busG.req_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_note", 32'(note0), 0);
        check("rst_velo", 32'(velo0), 0);
        check("rst_en", 32'(en0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_owner", 32'(owner0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_ready", 32'(bus0.req_ready), 0);
        check("rst_gap_busy", 32'(busyG), 0);
        rstn = 1'b1;
        nextCycle();
        #1;

        // Single request, contention, rest note and zero-time word.
        serveAll(4'b0100, {32'h0, 32'h05400003, 32'h0, 32'h0});
        serveAll(4'b1010, {32'h0a200002, 32'h0, 32'h07300001, 32'h0});
        serveAll(4'b0001, {96'h0, 32'h00000002});
        serveAll(4'b0010, {64'h0, 32'h09500000, 32'h0});

        for (int r = 0; r < 25; r++) begin
            words = {randWord(4), randWord(4), randWord(4), randWord(4)};
            mask  = 4'($urandom_range(1, 15));
            serveAll(mask, words);
        end

        // Abort mid-note at a fixed then random cycle of a 12-cycle note.
        for (int a = 0; a < 3; a++) begin
            abortAt = (a == 0) ? 4 : $urandom_range(0, 11);
            bus0.req_data  = {32'h0, 32'h0b600003, 64'h0};
            bus0.req_valid = 4'b0100;
            #1;
            check("abort_grant", 32'(bus0.req_ready), 32'h4);
            nextCycle();
            bus0.req_valid = 4'b0000;
            #1;
            for (int c = 0; c < abortAt; c++) begin
                check("abort_pre_en", 32'(en0), 1);
                nextCycle();
                #1;
            end
            abort0 = 1'b1;
            nextCycle();
            abort0 = 1'b0;
            #1;
            check("abort_busy", 32'(busy0), 0);
            check("abort_en", 32'(en0), 0);
            check("abort_note", 32'(note0), 0);
            for (int c = 0; c < 14; c++) begin
                check("abort_no_done", 32'(done0), 0);
                nextCycle();
                #1;
            end
        end

        // Abort in IDLE suppresses the grant.
        bus0.req_data  = {32'h0, 32'h0e100001, 64'h0};
        bus0.req_valid = 4'b0100;
        abort0 = 1'b1;
        #1;
        check("idle_abort_ready", 32'(bus0.req_ready), 0);
        nextCycle();
        #1;
        check("idle_abort_busy", 32'(busy0), 0);
        abort0 = 1'b0;
        serveAll(4'b0100, {32'h0, 32'h0e100001, 64'h0});

        // Lower-index request arriving while req 3 plays.
        bus0.req_data  = {32'h0c700003, 64'h0, 32'h0d100002};
        bus0.req_valid = 4'b1000;
        #1;
        check("pre_grant3", 32'(bus0.req_ready), 32'h8);
        nextCycle();
        bus0.req_valid = 4'b0000;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("pre_note3", 32'(note0), 32'h0c);
            nextCycle();
            #1;
        end
        bus0.req_valid = 4'b0001;
        #1;
`ifdef TONE_SCHED_PREEMPT_EN
        check("pre_ready0", 32'(bus0.req_ready), 32'h1);
        nextCycle();
        bus0.req_valid = 4'b0000;
        #1;
        check("pre_owner", 32'(owner0), 0);
        for (int c = 0; c < 8; c++) begin
            check("pre_note0", 32'(note0), 32'h0d);
            check("pre_no_done", 32'(done0), 0);
            nextCycle();
            #1;
        end
        check("pre_done0", 32'(done0), 32'h1);
`else
        for (int c = 3; c < 12; c++) begin
            check("wait_ready", 32'(bus0.req_ready), 0);
            check("wait_note3", 32'(note0), 32'h0c);
            nextCycle();
            #1;
        end
        check("wait_done3", 32'(done0), 32'h8);
        check("wait_grant0", 32'(bus0.req_ready), 32'h1);
        nextCycle();
        bus0.req_valid = 4'b0000;
        #1;
        for (int c = 0; c < 8; c++) begin
            check("wait_note0", 32'(note0), 32'h0d);
            nextCycle();
            #1;
        end
        check("wait_done0", 32'(done0), 32'h1);
`endif
        nextCycle();
        #1;

        // Gap build: two back-to-back 1 ms notes from req 0.
        busG.req_data  = {96'h0, 32'h11220001};
        busG.req_valid = 4'b0001;
        #1;
        check("gap_grant1", 32'(busG.req_ready), 32'h1);
        nextCycle();
        busG.req_data = {96'h0, 32'h33440001};
        #1;
        for (int c = 0; c < TDIV; c++) begin
            check("gap_play1_en", 32'(enG), 1);
            check("gap_play1_note", 32'(noteG), 32'h11);
            check("gap_play1_velo", 32'(veloG), 32'h22);
            check("gap_play1_ready", 32'(busG.req_ready), 0);
            nextCycle();
            #1;
        end
        for (int c = 0; c < GAPMS * TDIV; c++) begin
            check("gap1_en", 32'(enG), 0);
            check("gap1_busy", 32'(busyG), 1);
            check("gap1_ready", 32'(busG.req_ready), 0);
            check("gap1_done", 32'(doneG), (c == 0) ? 1 : 0);
            nextCycle();
            #1;
        end
        check("gap_idle_busy", 32'(busyG), 0);
        check("gap_grant2", 32'(busG.req_ready), 32'h1);
        nextCycle();
        busG.req_valid = 4'b0000;
        #1;
        for (int c = 0; c < TDIV; c++) begin
            check("gap_play2_note", 32'(noteG), 32'h33);
            check("gap_play2_en", 32'(enG), 1);
            nextCycle();
            #1;
        end
        for (int c = 0; c < GAPMS * TDIV; c++) begin
            check("gap2_en", 32'(enG), 0);
            check("gap2_busy", 32'(busyG), 1);
            check("gap2_done", 32'(doneG), (c == 0) ? 1 : 0);
            nextCycle();
            #1;
        end
        check("gap_end_busy", 32'(busyG), 0);
        check("gap_owner", 32'(ownerG), 0);

        // Asynchronous reset in the middle of a note.
        bus0.req_data  = {64'h0, 32'h21000004, 32'h0};
        bus0.req_valid = 4'b0010;
        #1;
        check("arst_grant", 32'(bus0.req_ready), 32'h2);
        nextCycle();
        bus0.req_valid = 4'b0000;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("arst_pre_en", 32'(en0), 1);
            nextCycle();
            #1;
        end
        #1;
        rstn = 1'b0;
        #1;
        check("arst_en", 32'(en0), 0);
        check("arst_busy", 32'(busy0), 0);
        check("arst_note", 32'(note0), 0);
        check("arst_owner", 32'(owner0), 0);
        nextCycle();
        rstn = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            check("arst_silent", 32'(en0), 0);
            check("arst_no_done", 32'(done0), 0);
            nextCycle();
            #1;
        end
        serveAll(4'b0010, {64'h0, 32'h21000004, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
